// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, latencies and the HI/LO result
// function shared by the multiply/divide unit.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;

  localparam int MDU_MULT_T = 5;
  localparam int MDU_DIV_T  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } mdu_res_t;

  function automatic logic is_long_op(
    input logic [3:0] op
  );
    return (op == MDU_MULT)  ||
           (op == MDU_MULTU) ||
           (op == MDU_DIV)   ||
           (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(
    input logic [3:0] op
  );
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Signed divide runs on magnitudes, so the
  // 0x80000000 / -1 corner needs no special case.
  function automatic mdu_res_t mdu_compute(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    mdu_res_t    r;
    logic [63:0] p;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] m;
    r  = '0;
    p  = '0;
    ma = a;
    mb = b;
    if (op == MDU_DIV) begin
      ma = a[31] ? (32'd0 - a) : a;
      mb = b[31] ? (32'd0 - b) : b;
    end
    d = (mb == 32'd0) ? 32'd1 : mb;
    q = ma / d;
    m = ma % d;
    case (op)
      MDU_MULT: begin
        p    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
        r.wr = 1'b1;
      end
      MDU_MULTU: begin
        p    = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
        r.wr = 1'b1;
      end
      MDU_DIV: begin
        r.lo = (a[31] ^ b[31]) ? (32'd0 - q) : q;
        r.hi = a[31] ? (32'd0 - m) : m;
        r.wr = (b != 32'd0);
      end
      MDU_DIVU: begin
        r.lo = q;
        r.hi = m;
        r.wr = (b != 32'd0);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage request and HI/LO/busy
// response bundle of the multiply/divide unit.
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  logic [3:0]  MDUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start,
    output MDUControl,
    output A,
    output B,
    input  busy,
    input  HI,
    input  LO
  );

  modport slave (
    input  start,
    input  MDUControl,
    input  A,
    input  B,
    output busy,
    output HI,
    output LO
  );

endinterface

// File: rtl/mdu.sv
// mdu: fixed-latency mult/div unit with HI/LO;
// results land in HI/LO on the cycle busy drops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_T,
  parameter int DIV_CYCLES  = MDU_DIV_T
) (
  input  logic clk,
  input  logic reset_n,
  mdu_if.slave bus
);

  localparam int CMAX =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                               : DIV_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] LD_MUL  = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] LD_DIV  = CW'(DIV_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   hi_tmp_q, hi_tmp_d;
  logic [31:0]   lo_tmp_q, lo_tmp_d;
  logic          wr_q, wr_d;

  mdu_res_t res;

  assign res = mdu_compute(bus.MDUControl,
                           bus.A, bus.B);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    wr_d     = wr_q;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        if (is_long_op(bus.MDUControl)) begin
          state_d  = S_RUN;
          cnt_d    = is_div_op(bus.MDUControl)
                     ? LD_DIV : LD_MUL;
          hi_tmp_d = res.hi;
          lo_tmp_d = res.lo;
          wr_d     = res.wr;
        end else if (bus.MDUControl == MDU_MTHI) begin
          hi_d = bus.A;
        end else if (bus.MDUControl == MDU_MTLO) begin
          lo_d = bus.A;
        end
      end
    end else begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = S_IDLE;
        // divide by zero leaves HI/LO untouched
        if (wr_q) begin
          hi_d = hi_tmp_q;
          lo_d = lo_tmp_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      wr_q     <= wr_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed checks of mult/div latency,
// HI/LO results, reset and dropped starts.
module tb_mdu;
  import mdu_pkg::*;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total;
  int   n;

  mdu_if bus ();

  mdu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  // call at a negedge; returns at the negedge
  // just after the accepting posedge
  task automatic issue(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    bus.start      = 1'b1;
    bus.MDUControl = op;
    bus.A          = a;
    bus.B          = b;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.MDUControl = MDU_NONE;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    pass_cnt       = 0;
    total          = 0;
    bus.start      = 1'b0;
    bus.MDUControl = MDU_NONE;
    bus.A          = '0;
    bus.B          = '0;
    reset_n        = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: async reset mid-run abandons the op
    issue(MDU_MTHI, 32'h55, 32'd0);
    issue(MDU_MTLO, 32'h66, 32'd0);
    chk("t1_pre_hi", bus.HI, 32'h55);
    issue(MDU_MULT, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_hi", bus.HI, 32'd0);
    chk("t1_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t1_after_busy", 32'(bus.busy), 32'd0);
    chk("t1_after_hi", bus.HI, 32'd0);
    chk("t1_after_lo", bus.LO, 32'd0);

    // 2: signed mult
    issue(MDU_MULT, 32'hFFFFFFFD, 32'd5);
    wait_idle(n);
    chk("t2_cycles", 32'(n), 32'd5);
    chk("t2_hi", bus.HI, 32'hFFFFFFFF);
    chk("t2_lo", bus.LO, 32'hFFFFFFF1);

    // 3: unsigned mult, old HI visible while busy
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
    chk("t3_hold_hi", bus.HI, 32'hFFFFFFFF);
    wait_idle(n);
    chk("t3_cycles", 32'(n), 32'd5);
    chk("t3_hi", bus.HI, 32'h00000001);
    chk("t3_lo", bus.LO, 32'hFFFFFFFE);

    // 4: signed and unsigned divide
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("t4_div_cycles", 32'(n), 32'd10);
    chk("t4_div_lo", bus.LO, 32'hFFFFFFFD);
    chk("t4_div_hi", bus.HI, 32'hFFFFFFFF);
    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    chk("t4_divu_cycles", 32'(n), 32'd10);
    chk("t4_divu_lo", bus.LO, 32'd3);
    chk("t4_divu_hi", bus.HI, 32'd1);
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("t4_ovf_cycles", 32'(n), 32'd10);
    chk("t4_ovf_lo", bus.LO, 32'h80000000);
    chk("t4_ovf_hi", bus.HI, 32'd0);

    // 5: mthi/mtlo then divide by zero
    issue(MDU_MTHI, 32'h11, 32'd0);
    chk("t5_mthi_busy", 32'(bus.busy), 32'd0);
    issue(MDU_MTLO, 32'h22, 32'd0);
    chk("t5_mtlo_busy", 32'(bus.busy), 32'd0);
    chk("t5_pre_hi", bus.HI, 32'h11);
    chk("t5_pre_lo", bus.LO, 32'h22);
    issue(MDU_DIVU, 32'd9, 32'd0);
    wait_idle(n);
    chk("t5_cycles", 32'(n), 32'd10);
    chk("t5_hi", bus.HI, 32'h11);
    chk("t5_lo", bus.LO, 32'h22);

    // 6: start during busy is dropped
    issue(MDU_MULT, 32'd6, 32'd7);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.MDUControl = MDU_MTLO;
    bus.A          = 32'hAB;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.MDUControl = MDU_NONE;
    chk("t6_hold_lo", bus.LO, 32'h22);
    wait_idle(n);
    chk("t6_cycles", 32'(n + 2), 32'd5);
    chk("t6_lo", bus.LO, 32'd42);
    chk("t6_hi", bus.HI, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
